aes_block_fifo: RTL and testbench
=================================

Name: aes_block_fifo

Overview:
Parametrised synchronous FIFO that buffers AES blocks between the communication front end and the AES core. It replaces the fixed 7-entry, multi-cycle-per-operation buffer with a configurable design. The new design accepts one write and one read per cycle, including both in the same cycle. It adds occupancy count, almost-full, and sticky overflow/underflow error flags. It sits between the UART/packet deframer (writer) and the AES core input controller (reader).

Parameters:
DATA_W, 128, width of one stored word (one AES block by default)
DEPTH, 8, number of entries; must be a power of two and >= 2
AFULL_THRESH, 6, almost_full asserts when count >= AFULL_THRESH; legal range 1..DEPTH
(derived) ADDR_W = clog2(DEPTH); count width CNT_W = ADDR_W+1

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  synchronous, active-high reset
din  in  DATA_W  write data
write_en  in  1  write request
read_en  in  1  read request
clear_err  in  1  clears sticky overflow/underflow
dout  out  DATA_W  read data, registered
dout_valid  out  1  one-cycle pulse: dout updated by an accepted read
count  out  CNT_W  number of stored entries, 0..DEPTH
empty  out  1  count == 0
full  out  1  count == DEPTH
almost_full  out  1  count >= AFULL_THRESH
overflow  out  1  sticky: a write was attempted while full
underflow  out  1  sticky: a read was attempted while empty

Behaviour:
- Reset (reset=1 at a clk edge) has priority over everything else. After the edge:
  - wr_ptr=0, rd_ptr=0, count=0
  - dout=0, dout_valid=0, overflow=0, underflow=0
  - so empty=1, full=0, almost_full=0
  - Storage array is not reset; content is discarded logically.
  - A reset mid-stream drops all entries; a read in the reset cycle is ignored.
- Flags: empty/full/almost_full are decoded directly from the count register, so they change in the cycle after the edge that changes count.
- Write acceptance: wr_acc = write_en & ~full.
  - On wr_acc: mem[wr_ptr] <= din; wr_ptr increments modulo DEPTH, wrapping DEPTH-1 -> 0.
- Read acceptance: rd_acc = read_en & ~empty.
  - On rd_acc: dout <= mem[rd_ptr]; dout_valid <= 1; rd_ptr increments modulo DEPTH.
  - Otherwise dout holds its value and dout_valid <= 0.
  - Read latency: data appears at the edge after the request, i.e. 1 cycle.
- Count update:
  - +1 on wr_acc only
  - -1 on rd_acc only
  - unchanged when both are accepted or neither is
- Simultaneous read and write:
  - Not full and not empty: both accepted, count unchanged.
  - Empty: write accepted, read rejected (no bypass), so underflow is set.
  - Full: read accepted, write rejected, so overflow is set. The writer must not rely on a same-cycle read freeing space.
- Error flags:
  - overflow <= 1 when write_en & full; underflow <= 1 when read_en & empty.
  - Both stay set until a cycle with clear_err=1 and no new error event. A new error in the same cycle as clear_err wins.
  - Rejected operations change no pointer, count or data.
- Ordering: strict first-in, first-out across wrap-around. Every accepted write is eventually readable exactly once.
- No combinational path from inputs to outputs.

Decomposition:
- Package aes_fifo_pkg holds:
  - AES_BLOCK_W = 128
  - FIFO_DEPTH_DEFAULT = 8
  - FIFO_AFULL_DEFAULT = 6
  - a function computing clog2 for ADDR_W/CNT_W
- One natural sub-module: aes_fifo_mem, a simple dual-port array with one synchronous write port and one registered synchronous read port. It holds no reset logic.
- Pointer/count/flag control stays in aes_block_fifo.

Test Plan:
- Reset, then idle: count=0, empty=1, full=0, almost_full=0, dout=0, dout_valid=0, overflow=underflow=0.
- Write 0x...01 through 0x...08 on 8 consecutive cycles, then read 8 consecutive cycles:
  - almost_full=1 once count=6; full=1 at count=8
  - dout returns 0x..01..0x..08 in order, each 1 cycle after its read_en, with dout_valid high 8 cycles
  - empty=1 at end
- Ninth write while full (din=0xDEAD):
  - overflow=1, count stays 8
  - subsequent reads return 0x..01..0x..08; 0xDEAD never appears
- Read while empty: underflow=1, dout_valid=0, dout unchanged, count=0.
  - clear_err for one cycle gives underflow=0.
  - clear_err in the same cycle as another empty read leaves underflow=1.
- Prefill 3 entries, then 20 cycles of simultaneous write_en+read_en with an incrementing pattern:
  - count stays 3; pointers wrap at least twice
  - output sequence equals the input sequence delayed by 3 entries
- Mid-stream reset with count=5 and a read pending:
  - next cycle count=0, empty=1, dout=0, dout_valid=0
  - a fresh write/read pair returns only the new data

Source files
------------

// File: rtl/aes_fifo_pkg.sv
// Shared constants and helpers for the AES block FIFO.
// Defaults size the buffer for one AES block per entry.
package aes_fifo_pkg;

    localparam int unsigned AES_BLOCK_W        = 128;
    localparam int unsigned FIFO_DEPTH_DEFAULT = 8;
    localparam int unsigned FIFO_AFULL_DEFAULT = 6;

    // Number of address bits needed to index `value` entries.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned bits;
        int unsigned rem;
        bits = 0;
        rem  = value - 1;
        while (rem > 0) begin
            bits = bits + 1;
            rem  = rem >> 1;
        end
        return bits;
    endfunction

endpackage

// File: rtl/aes_fifo_mem.sv
// Simple dual-port storage array: one synchronous write port and one registered read port.
// The array and the read register are not reset; the owner qualifies the data.
module aes_fifo_mem #(
    parameter int unsigned DATA_W = 128,
    parameter int unsigned DEPTH  = 8,
    parameter int unsigned ADDR_W = 3
) (
    input  logic              i_clk,
    input  logic              i_wr_en,
    input  logic [ADDR_W-1:0] i_wr_addr,
    input  logic [DATA_W-1:0] i_wr_data,
    input  logic              i_rd_en,
    input  logic [ADDR_W-1:0] i_rd_addr,
    output logic [DATA_W-1:0] o_rd_data
);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_rd_data;

    always_ff @(posedge i_clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rd_en) begin
            r_rd_data <= r_mem[i_rd_addr];
        end
    end

    assign o_rd_data = r_rd_data;

endmodule

// File: rtl/aes_block_fifo.sv
// Synchronous FIFO buffering AES blocks between the packet deframer and the AES core.
// One write and one read per cycle, occupancy count, almost-full and sticky error flags.
module aes_block_fifo
    import aes_fifo_pkg::*;
#(
    parameter int unsigned DATA_W       = AES_BLOCK_W,
    parameter int unsigned DEPTH        = FIFO_DEPTH_DEFAULT,
    parameter int unsigned AFULL_THRESH = FIFO_AFULL_DEFAULT,
    localparam int unsigned ADDR_W      = clog2(DEPTH),
    localparam int unsigned CNT_W       = ADDR_W + 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] din,
    input  logic              write_en,
    input  logic              read_en,
    input  logic              clear_err,
    output logic [DATA_W-1:0] dout,
    output logic              dout_valid,
    output logic [CNT_W-1:0]  count,
    output logic              empty,
    output logic              full,
    output logic              almost_full,
    output logic              overflow,
    output logic              underflow
);

    logic [ADDR_W-1:0] r_wr_ptr;
    logic [ADDR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0]  r_count;
    logic              r_dout_valid;
    logic              r_has_data;
    logic              r_overflow;
    logic              r_underflow;

    logic              w_empty;
    logic              w_full;
    logic              w_wr_acc;
    logic              w_rd_acc;
    logic [DATA_W-1:0] w_rd_data;

    assign w_empty  = (r_count == '0);
    assign w_full   = (r_count == CNT_W'(DEPTH));
    // Gating with reset keeps the array and its read register untouched in the reset cycle.
    assign w_wr_acc = write_en & ~w_full & ~reset;
    assign w_rd_acc = read_en & ~w_empty & ~reset;

    aes_fifo_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_mem (
        .i_clk     (clk),
        .i_wr_en   (w_wr_acc),
        .i_wr_addr (r_wr_ptr),
        .i_wr_data (din),
        .i_rd_en   (w_rd_acc),
        .i_rd_addr (r_rd_ptr),
        .o_rd_data (w_rd_data)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
            r_dout_valid <= 1'b0;
            r_has_data   <= 1'b0;
            r_overflow   <= 1'b0;
            r_underflow  <= 1'b0;
        end else begin
            if (w_wr_acc) begin
                r_wr_ptr <= r_wr_ptr + ADDR_W'(1);
            end
            if (w_rd_acc) begin
                r_rd_ptr   <= r_rd_ptr + ADDR_W'(1);
                r_has_data <= 1'b1;
            end
            case ({w_wr_acc, w_rd_acc})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
            r_dout_valid <= w_rd_acc;
            // A fresh error event outranks a same-cycle clear.
            if (write_en & w_full) begin
                r_overflow <= 1'b1;
            end else if (clear_err) begin
                r_overflow <= 1'b0;
            end
            if (read_en & w_empty) begin
                r_underflow <= 1'b1;
            end else if (clear_err) begin
                r_underflow <= 1'b0;
            end
        end
    end

    // The read register is unreset storage, so dout reads as zero until the first accepted read.
    assign dout        = r_has_data ? w_rd_data : '0;
    assign dout_valid  = r_dout_valid;
    assign count       = r_count;
    assign empty       = w_empty;
    assign full        = w_full;
    assign almost_full = (r_count >= CNT_W'(AFULL_THRESH));
    assign overflow    = r_overflow;
    assign underflow   = r_underflow;

endmodule

// File: tb/tb_aes_block_fifo.sv
// Directed self-checking bench for aes_block_fifo at default parameters (128 x 8, afull at 6).
module tb_aes_block_fifo;

    localparam int DW = 128;

    logic          clk;
    logic          reset;
    logic [DW-1:0] din;
    logic          write_en;
    logic          read_en;
    logic          clear_err;
    logic [DW-1:0] dout;
    logic          dout_valid;
    logic [3:0]    count;
    logic          empty;
    logic          full;
    logic          almost_full;
    logic          overflow;
    logic          underflow;

    int n_cmp = 0;
    int n_err = 0;

    aes_block_fifo dut (
        .clk         (clk),
        .reset       (reset),
        .din         (din),
        .write_en    (write_en),
        .read_en     (read_en),
        .clear_err   (clear_err),
        .dout        (dout),
        .dout_valid  (dout_valid),
        .count       (count),
        .empty       (empty),
        .full        (full),
        .almost_full (almost_full),
        .overflow    (overflow),
        .underflow   (underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [DW-1:0] blk(input int n);
        logic [31:0] w;
        w = 32'(n);
        return {w ^ 32'hA5000000, w ^ 32'h5A000000, w ^ 32'h3C000000, w};
    endfunction

    // Apply one cycle of inputs, then sample 1ns after the edge.
    task automatic cycle(input logic rs, input logic we, input logic re, input logic ce,
                         input logic [DW-1:0] d);
        reset     = rs;
        write_en  = we;
        read_en   = re;
        clear_err = ce;
        din       = d;
        @(posedge clk);
        #1;
        reset     = 1'b0;
        write_en  = 1'b0;
        read_en   = 1'b0;
        clear_err = 1'b0;
    endtask

    task automatic test_reset();
        cycle(1'b1, 1'b0, 1'b0, 1'b0, '0);
        cycle(1'b0, 1'b0, 1'b0, 1'b0, '0);
        n_cmp++; if (count !== 4'd0) begin n_err++; $display("FAIL reset_count got %0d want 0", count); end
        n_cmp++; if (empty !== 1'b1) begin n_err++; $display("FAIL reset_empty got %b want 1", empty); end
        n_cmp++; if (full !== 1'b0) begin n_err++; $display("FAIL reset_full got %b want 0", full); end
        n_cmp++; if (almost_full !== 1'b0) begin n_err++; $display("FAIL reset_afull got %b want 0", almost_full); end
        n_cmp++; if (dout !== '0) begin n_err++; $display("FAIL reset_dout got %h want 0", dout); end
        n_cmp++; if (dout_valid !== 1'b0) begin n_err++; $display("FAIL reset_dvalid got %b want 0", dout_valid); end
        n_cmp++; if ({overflow, underflow} !== 2'b00) begin n_err++; $display("FAIL reset_err got %b%b want 00", overflow, underflow); end
    endtask

    task automatic test_fill_drain();
        for (int k = 1; k <= 8; k++) begin
            cycle(1'b0, 1'b1, 1'b0, 1'b0, blk(k));
            n_cmp++; if (count !== 4'(k)) begin n_err++; $display("FAIL fill_count[%0d] got %0d want %0d", k, count, k); end
            n_cmp++; if (almost_full !== (k >= 6)) begin n_err++; $display("FAIL fill_afull[%0d] got %b want %b", k, almost_full, k >= 6); end
            n_cmp++; if (full !== (k == 8)) begin n_err++; $display("FAIL fill_full[%0d] got %b want %b", k, full, k == 8); end
        end
        for (int j = 1; j <= 8; j++) begin
            cycle(1'b0, 1'b0, 1'b1, 1'b0, '0);
            n_cmp++; if (dout !== blk(j)) begin n_err++; $display("FAIL drain_dout[%0d] got %h want %h", j, dout, blk(j)); end
            n_cmp++; if (dout_valid !== 1'b1) begin n_err++; $display("FAIL drain_dvalid[%0d] got %b want 1", j, dout_valid); end
            n_cmp++; if (count !== 4'(8 - j)) begin n_err++; $display("FAIL drain_count[%0d] got %0d want %0d", j, count, 8 - j); end
        end
        cycle(1'b0, 1'b0, 1'b0, 1'b0, '0);
        n_cmp++; if (dout_valid !== 1'b0) begin n_err++; $display("FAIL drain_idle_dvalid got %b want 0", dout_valid); end
        n_cmp++; if (empty !== 1'b1) begin n_err++; $display("FAIL drain_empty got %b want 1", empty); end
        n_cmp++; if (dout !== blk(8)) begin n_err++; $display("FAIL drain_hold got %h want %h", dout, blk(8)); end
    endtask

    task automatic test_overflow();
        for (int k = 1; k <= 8; k++) cycle(1'b0, 1'b1, 1'b0, 1'b0, blk(k));
        n_cmp++; if (full !== 1'b1) begin n_err++; $display("FAIL ovf_prefull got %b want 1", full); end
        cycle(1'b0, 1'b1, 1'b0, 1'b0, DW'(32'hDEAD));
        n_cmp++; if (overflow !== 1'b1) begin n_err++; $display("FAIL ovf_flag got %b want 1", overflow); end
        n_cmp++; if (count !== 4'd8) begin n_err++; $display("FAIL ovf_count got %0d want 8", count); end
        cycle(1'b0, 1'b0, 1'b0, 1'b1, '0);
        n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL ovf_clear got %b want 0", overflow); end
        // Full with simultaneous read: the read wins, the write is rejected.
        cycle(1'b0, 1'b1, 1'b1, 1'b0, DW'(32'hDEAD));
        n_cmp++; if (overflow !== 1'b1) begin n_err++; $display("FAIL ovf_rw_flag got %b want 1", overflow); end
        n_cmp++; if (count !== 4'd7) begin n_err++; $display("FAIL ovf_rw_count got %0d want 7", count); end
        n_cmp++; if (dout !== blk(1)) begin n_err++; $display("FAIL ovf_rw_dout got %h want %h", dout, blk(1)); end
        for (int j = 2; j <= 8; j++) begin
            cycle(1'b0, 1'b0, 1'b1, 1'b0, '0);
            n_cmp++; if (dout !== blk(j)) begin n_err++; $display("FAIL ovf_dout[%0d] got %h want %h", j, dout, blk(j)); end
        end
        n_cmp++; if (empty !== 1'b1) begin n_err++; $display("FAIL ovf_empty got %b want 1", empty); end
        cycle(1'b0, 1'b0, 1'b0, 1'b1, '0);
        n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL ovf_clear2 got %b want 0", overflow); end
    endtask

    task automatic test_underflow();
        cycle(1'b0, 1'b0, 1'b1, 1'b0, '0);
        n_cmp++; if (underflow !== 1'b1) begin n_err++; $display("FAIL udf_flag got %b want 1", underflow); end
        n_cmp++; if (dout_valid !== 1'b0) begin n_err++; $display("FAIL udf_dvalid got %b want 0", dout_valid); end
        n_cmp++; if (dout !== blk(8)) begin n_err++; $display("FAIL udf_dout got %h want %h", dout, blk(8)); end
        n_cmp++; if (count !== 4'd0) begin n_err++; $display("FAIL udf_count got %0d want 0", count); end
        cycle(1'b0, 1'b0, 1'b0, 1'b1, '0);
        n_cmp++; if (underflow !== 1'b0) begin n_err++; $display("FAIL udf_clear got %b want 0", underflow); end
        cycle(1'b0, 1'b0, 1'b1, 1'b1, '0);
        n_cmp++; if (underflow !== 1'b1) begin n_err++; $display("FAIL udf_clear_race got %b want 1", underflow); end
        cycle(1'b0, 1'b0, 1'b0, 1'b1, '0);
        // Empty with simultaneous write: write accepted, read rejected, no bypass.
        cycle(1'b0, 1'b1, 1'b1, 1'b0, blk(50));
        n_cmp++; if (count !== 4'd1) begin n_err++; $display("FAIL udf_rw_count got %0d want 1", count); end
        n_cmp++; if (underflow !== 1'b1) begin n_err++; $display("FAIL udf_rw_flag got %b want 1", underflow); end
        n_cmp++; if (dout_valid !== 1'b0) begin n_err++; $display("FAIL udf_rw_dvalid got %b want 0", dout_valid); end
        cycle(1'b0, 1'b0, 1'b1, 1'b1, '0);
        n_cmp++; if (dout !== blk(50)) begin n_err++; $display("FAIL udf_rw_dout got %h want %h", dout, blk(50)); end
        n_cmp++; if (underflow !== 1'b0) begin n_err++; $display("FAIL udf_rw_clear got %b want 0", underflow); end
    endtask

    task automatic test_back_to_back();
        for (int k = 0; k < 3; k++) cycle(1'b0, 1'b1, 1'b0, 1'b0, blk(100 + k));
        for (int i = 0; i < 20; i++) begin
            cycle(1'b0, 1'b1, 1'b1, 1'b0, blk(103 + i));
            n_cmp++; if (dout !== blk(100 + i)) begin n_err++; $display("FAIL b2b_dout[%0d] got %h want %h", i, dout, blk(100 + i)); end
            n_cmp++; if (dout_valid !== 1'b1) begin n_err++; $display("FAIL b2b_dvalid[%0d] got %b want 1", i, dout_valid); end
            n_cmp++; if (count !== 4'd3) begin n_err++; $display("FAIL b2b_count[%0d] got %0d want 3", i, count); end
        end
        for (int j = 0; j < 3; j++) begin
            cycle(1'b0, 1'b0, 1'b1, 1'b0, '0);
            n_cmp++; if (dout !== blk(120 + j)) begin n_err++; $display("FAIL b2b_tail[%0d] got %h want %h", j, dout, blk(120 + j)); end
        end
        n_cmp++; if ({overflow, underflow, empty} !== 3'b001) begin n_err++; $display("FAIL b2b_end got %b%b%b want 001", overflow, underflow, empty); end
    endtask

    task automatic test_midreset();
        for (int k = 0; k < 5; k++) cycle(1'b0, 1'b1, 1'b0, 1'b0, blk(200 + k));
        n_cmp++; if (count !== 4'd5) begin n_err++; $display("FAIL mrst_pre_count got %0d want 5", count); end
        cycle(1'b1, 1'b0, 1'b1, 1'b0, '0);
        n_cmp++; if (count !== 4'd0) begin n_err++; $display("FAIL mrst_count got %0d want 0", count); end
        n_cmp++; if (empty !== 1'b1) begin n_err++; $display("FAIL mrst_empty got %b want 1", empty); end
        n_cmp++; if (dout !== '0) begin n_err++; $display("FAIL mrst_dout got %h want 0", dout); end
        n_cmp++; if (dout_valid !== 1'b0) begin n_err++; $display("FAIL mrst_dvalid got %b want 0", dout_valid); end
        cycle(1'b0, 1'b1, 1'b0, 1'b0, blk(300));
        cycle(1'b0, 1'b0, 1'b1, 1'b0, '0);
        n_cmp++; if (dout !== blk(300)) begin n_err++; $display("FAIL mrst_new_dout got %h want %h", dout, blk(300)); end
        n_cmp++; if (dout_valid !== 1'b1) begin n_err++; $display("FAIL mrst_new_dvalid got %b want 1", dout_valid); end
        cycle(1'b0, 1'b0, 1'b1, 1'b0, '0);
        n_cmp++; if ({empty, underflow, dout_valid} !== 3'b110) begin n_err++; $display("FAIL mrst_end got %b%b%b want 110", empty, underflow, dout_valid); end
    endtask

    initial begin
        reset     = 1'b1;
        write_en  = 1'b0;
        read_en   = 1'b0;
        clear_err = 1'b0;
        din       = '0;
        test_reset();
        test_fill_drain();
        test_overflow();
        test_underflow();
        test_back_to_back();
        test_midreset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
